// File: rtl/enemy_tank_ai.sv
// enemy_tank_ai: autonomous per-enemy driver that produces one frame's worth of
// move/fire requests from tank feedback, tank/player positions and a 16-bit LFSR.
//
// state | meaning
// ------+-----------------------------------------------------------
// SPAWN | idle after reset/respawn; counts SPAWN_DELAY frames, never fires
// MOVE  | drive the move output matching dir for a randomized run length
// TURN  | idle pause, then pick the next heading (player-biased or random)
module enemy_tank_ai #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SPAWN_DELAY   = 60,
    parameter int          MOVE_MIN      = 32,
    parameter int          TURN_PAUSE    = 8,
    parameter int          FIRE_COOLDOWN = 60,
    parameter int          ALIGN_TOL     = 8,
    parameter int          STEP          = 2
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       blocked,
    input  logic       bullet_active,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic [3:0] dir,
    output logic [1:0] state
);

    localparam int TMAX_0 = (SPAWN_DELAY > FIRE_COOLDOWN) ? SPAWN_DELAY : FIRE_COOLDOWN;
    localparam int TMAX_1 = (TMAX_0 > MOVE_MIN + 63) ? TMAX_0 : MOVE_MIN + 63;
    localparam int TMAX   = (TMAX_1 > TURN_PAUSE) ? TMAX_1 : TURN_PAUSE;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_MOVE  = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] cool_q, cool_d;
    logic [3:0]    dir_q, dir_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          wb_q, wb_d;
    logic [9:0]    prev_x_q, prev_x_d;
    logic [9:0]    prev_y_q, prev_y_d;
    logic [3:0]    move_q, move_d;
    logic          fire_q, fire_d;

    logic [9:0]    dx_tank, dy_tank, dx_pl, dy_pl;
    logic          respawn, align_x, align_y, facing, trigger;
    logic [3:0]    cand_raw, cand;
    logic [TW-1:0] run_len;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Decision terms shared by the fire, turn and respawn logic.
    always_comb begin
        dx_tank = abs_diff(TankX, prev_x_q);
        dy_tank = abs_diff(TankY, prev_y_q);
        dx_pl   = abs_diff(TankX, PlayerX);
        dy_pl   = abs_diff(TankY, PlayerY);
        respawn = (dx_tank > 10'(STEP)) || (dy_tank > 10'(STEP));
        align_x = (dx_pl <= 10'(ALIGN_TOL));
        align_y = (dy_pl <= 10'(ALIGN_TOL));

        facing = 1'b0;
        case (dir_q)
            DIR_UP:    facing = align_x && (PlayerY < TankY);
            DIR_DOWN:  facing = align_x && (PlayerY > TankY);
            DIR_LEFT:  facing = align_y && (PlayerX < TankX);
            DIR_RIGHT: facing = align_y && (PlayerX > TankX);
            default:   facing = 1'b0;
        endcase
        trigger = facing || (lfsr_q[7:4] == 4'h0);

        if (align_x && lfsr_q[0]) begin
            cand_raw = (PlayerY < TankY) ? DIR_UP : DIR_DOWN;
        end else if (align_y && lfsr_q[0]) begin
            cand_raw = (PlayerX < TankX) ? DIR_LEFT : DIR_RIGHT;
        end else begin
            cand_raw = 4'b0001 << lfsr_q[2:1];
        end
        // After a collision never retry the heading that just got refused.
        cand = (wb_q && (cand_raw == dir_q)) ? {cand_raw[2:0], cand_raw[3]} : cand_raw;

        run_len = TW'(MOVE_MIN) + TW'(lfsr_q[5:0]);
    end

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        prev_x_d = TankX;
        prev_y_d = TankY;
        state_d  = state_q;
        timer_d  = timer_q;
        cool_d   = cool_q;
        dir_d    = dir_q;
        wb_d     = wb_q;
        move_d   = 4'h0;
        fire_d   = 1'b0;

        if (respawn) begin
            state_d = ST_SPAWN;
            timer_d = TW'(SPAWN_DELAY);
            wb_d    = 1'b0;
        end else if (enable) begin
            fire_d = (state_q != ST_SPAWN) && (cool_q == '0) && !bullet_active && trigger;
            if (state_q != ST_SPAWN) begin
                if (fire_d) begin
                    cool_d = TW'(FIRE_COOLDOWN);
                end else if (cool_q != '0) begin
                    cool_d = cool_q - TW'(1);
                end
            end

            case (state_q)
                ST_SPAWN: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        state_d = ST_MOVE;
                        timer_d = run_len;
                    end
                end
                ST_MOVE: begin
                    if (blocked) begin
                        state_d = ST_TURN;
                        timer_d = TW'(TURN_PAUSE);
                        wb_d    = 1'b1;
                    end else if (timer_q == '0) begin
                        state_d = ST_TURN;
                        timer_d = TW'(TURN_PAUSE);
                        wb_d    = 1'b0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_TURN: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        dir_d   = cand;
                        state_d = ST_MOVE;
                        timer_d = run_len;
                    end
                end
                default: begin
                    state_d = ST_SPAWN;
                    timer_d = TW'(SPAWN_DELAY);
                end
            endcase

            if (state_d == ST_MOVE) begin
                move_d = dir_d;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= ST_SPAWN;
            timer_q  <= TW'(SPAWN_DELAY);
            cool_q   <= TW'(FIRE_COOLDOWN);
            dir_q    <= DIR_DOWN;
            lfsr_q   <= SEED;
            wb_q     <= 1'b0;
            prev_x_q <= TankX;
            prev_y_q <= TankY;
            move_q   <= 4'h0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cool_q   <= cool_d;
            dir_q    <= dir_d;
            lfsr_q   <= lfsr_d;
            wb_q     <= wb_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            move_q   <= move_d;
            fire_q   <= fire_d;
        end
    end

    assign move_up    = move_q[0];
    assign move_down  = move_q[1];
    assign move_left  = move_q[2];
    assign move_right = move_q[3];
    assign fire       = fire_q;
    assign dir        = dir_q;
    assign state      = state_q;

endmodule

// File: tb/tb_enemy_tank_ai.sv
// Bench for enemy_tank_ai: directed spawn/respawn/freeze checks, then a closed-loop
// randomized run scored against an index-based behavioural model of the controller.
module tb_enemy_tank_ai;

    localparam int SPAWN_DELAY   = 60;
    localparam int MOVE_MIN      = 32;
    localparam int TURN_PAUSE    = 8;
    localparam int FIRE_COOLDOWN = 60;
    localparam int ALIGN_TOL     = 8;
    localparam int STEP          = 2;
    localparam int SEED          = 'hACE1;
    localparam int N_RANDOM      = 20000;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b0;
    logic       blocked = 1'b0;
    logic       bullet_active = 1'b0;
    logic [9:0] TankX = 10'd100;
    logic [9:0] TankY = 10'd100;
    logic [9:0] PlayerX = 10'd500;
    logic [9:0] PlayerY = 10'd50;
    logic       move_up, move_down, move_left, move_right, fire;
    logic [3:0] dir;
    logic [1:0] state;

    enemy_tank_ai dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .enable       (enable),
        .blocked      (blocked),
        .bullet_active(bullet_active),
        .TankX        (TankX),
        .TankY        (TankY),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .move_up      (move_up),
        .move_down    (move_down),
        .move_left    (move_left),
        .move_right   (move_right),
        .fire         (fire),
        .dir          (dir),
        .state        (state)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [10:0] exp_q[$];

    // Model: state 0/1/2, heading as index 0=up 1=down 2=left 3=right, mv=-1 when idle.
    int m_state, m_timer, m_cd, m_dir, m_lfsr, m_wb, m_px, m_py, m_mv, m_fire;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step();
        int  tx = int'(TankX);
        int  ty = int'(TankY);
        int  px = int'(PlayerX);
        int  py = int'(PlayerY);
        int  l  = m_lfsr;
        int  old_state = m_state;
        int  nd;
        bit  ax, ay, face;
        if (Reset) begin
            m_state = 0; m_timer = SPAWN_DELAY; m_cd = FIRE_COOLDOWN; m_dir = 1;
            m_lfsr = SEED; m_wb = 0; m_px = tx; m_py = ty; m_mv = -1; m_fire = 0;
            return;
        end
        m_lfsr = (l >> 1) ^ (((l % 2) == 1) ? 'hB400 : 0);
        m_fire = 0;
        m_mv   = -1;
        if (iabs(tx - m_px) > STEP || iabs(ty - m_py) > STEP) begin
            m_state = 0; m_timer = SPAWN_DELAY; m_wb = 0;
        end else if (enable) begin
            ax = iabs(tx - px) <= ALIGN_TOL;
            ay = iabs(ty - py) <= ALIGN_TOL;
            case (m_dir)
                0:       face = ax && (py < ty);
                1:       face = ax && (py > ty);
                2:       face = ay && (px < tx);
                default: face = ay && (px > tx);
            endcase
            if (old_state != 0 && m_cd == 0 && !bullet_active && (face || ((l >> 4) % 16) == 0))
                m_fire = 1;
            if (old_state != 0)
                m_cd = (m_fire != 0) ? FIRE_COOLDOWN : ((m_cd > 0) ? m_cd - 1 : 0);
            if (m_state == 0) begin
                if (m_timer > 0) m_timer--;
                else begin m_state = 1; m_timer = MOVE_MIN + l % 64; end
            end else if (m_state == 1) begin
                if (blocked) begin m_state = 2; m_timer = TURN_PAUSE; m_wb = 1; end
                else if (m_timer == 0) begin m_state = 2; m_timer = TURN_PAUSE; m_wb = 0; end
                else m_timer--;
            end else begin
                if (m_timer > 0) m_timer--;
                else begin
                    if (ax && (l % 2) == 1) nd = (py < ty) ? 0 : 1;
                    else if (ay && (l % 2) == 1) nd = (px < tx) ? 2 : 3;
                    else nd = (l >> 1) % 4;
                    if (m_wb != 0 && nd == m_dir) nd = (nd + 1) % 4;
                    m_dir = nd; m_state = 1; m_timer = MOVE_MIN + l % 64;
                end
            end
            if (m_state == 1) m_mv = m_dir;
        end
        m_px = tx;
        m_py = ty;
    endtask

    function automatic logic [10:0] exp_vec();
        logic [3:0] d = 4'b0001 << m_dir;
        return {m_mv == 0, m_mv == 1, m_mv == 2, m_mv == 3, m_fire != 0, d, 2'(m_state)};
    endfunction

    // Inputs must already be set; the edge is predicted at the negedge and outputs settle by return.
    task automatic step();
        @(negedge frame_clk);
        model_step();
        exp_q.push_back(exp_vec());
        cyc++;
        @(posedge frame_clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        logic [10:0] e, a;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {move_up, move_down, move_left, move_right, fire, dir, state};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard cycle=%0d got=%b expected=%b (up,dn,lt,rt,fire,dir,state)",
                             cyc, a, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int tx, ty, nx, ny, en_low, mode;
        Reset = 1'b1; enable = 1'b1;
        step();
        check("reset_state", {28'h0, 2'b00, state}, 32'h0);
        check("reset_outputs", {27'h0, move_up, move_down, move_left, move_right, fire}, 32'h0);
        check("reset_dir", {28'h0, dir}, 32'h2);
        Reset = 1'b0;

        for (int k = 1; k <= SPAWN_DELAY; k++) begin
            step();
            check("spawn_idle", {25'h0, move_up, move_down, move_left, move_right, fire, state}, 32'h0);
        end
        step();
        check("spawn_exit_state", {30'h0, state}, 32'h1);
        check("spawn_exit_move", {28'h0, move_up, move_down, move_left, move_right}, 32'b0100);

        TankX = 10'd270;
        step();
        check("respawn_state", {30'h0, state}, 32'h0);
        check("respawn_outputs", {27'h0, move_up, move_down, move_left, move_right, fire}, 32'h0);

        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("freeze_outputs", {25'h0, move_up, move_down, move_left, move_right, fire, state}, 32'h0);
        end
        enable = 1'b1;

        en_low = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            tx = int'(TankX);
            ty = int'(TankY);
            blocked = ($urandom_range(0, 49) == 0);
            if (m_mv >= 0) begin
                nx = tx + ((m_mv == 3) ? STEP : (m_mv == 2) ? -STEP : 0);
                ny = ty + ((m_mv == 1) ? STEP : (m_mv == 0) ? -STEP : 0);
                if ($urandom_range(0, 39) == 0 || nx < 16 || nx > 600 || ny < 16 || ny > 600)
                    blocked = 1'b1;
                else begin tx = nx; ty = ny; end
            end
            if ($urandom_range(0, 799) == 0) begin
                tx = $urandom_range(16, 600);
                ty = $urandom_range(16, 600);
            end
            TankX = 10'(tx);
            TankY = 10'(ty);

            if ($urandom_range(0, 24) == 0) begin
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    PlayerX = 10'($urandom_range(0, 1023));
                    PlayerY = 10'($urandom_range(0, 1023));
                end else if (mode == 1) begin
                    nx = tx + $urandom_range(0, 20) - 10;
                    PlayerX = 10'((nx < 0) ? 0 : nx);
                    PlayerY = 10'($urandom_range(0, 1023));
                end else begin
                    ny = ty + $urandom_range(0, 20) - 10;
                    PlayerY = 10'((ny < 0) ? 0 : ny);
                    PlayerX = 10'($urandom_range(0, 1023));
                end
            end

            if (en_low > 0) en_low--;
            else if ($urandom_range(0, 99) < 2) en_low = $urandom_range(1, 12);
            enable = (en_low == 0);
            bullet_active = ($urandom_range(0, 2) == 0);
            Reset = ($urandom_range(0, 5999) == 0);

            step();
            if (failures > 40) break;
        end
        Reset = 1'b0;

        check("scoreboard_drain", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
